reduce_extreme: RTL and testbench

REDUCE_EXTREME -- requirements
Module: reduce_extreme

---
 rtl/reduce_extreme.sv | 169 ++++++++++++++++
 tb/tb_reduce_extreme.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_extreme.sv
// Per-lane min/max reduction over a memory run, with a pass-through write of every element
// read and a held result that waits for downstream acceptance.
module reduce_extreme #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned NCH     = 4,
    parameter int unsigned FP_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW:0]       len,
    input  logic              mode_min,
    output logic              ready,
    output logic [AW-1:0]     rd_addr,
    input  logic [NCH*DW-1:0] rd_data,
    output logic [AW-1:0]     wr_addr,
    output logic [NCH*DW-1:0] wr_data,
    output logic              wr_ena,
    output logic [NCH*DW-1:0] result,
    output logic [NCH*AW-1:0] result_idx,
    output logic              done,
    input  logic              downstream_ready
);

    localparam logic [DW-1:0] ID_MAX = (FP_MODE != 0) ? DW'(32'hFF80_0000) : {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ID_MIN = (FP_MODE != 0) ? DW'(32'h7F80_0000) : {1'b0, {(DW-1){1'b1}}};
    localparam int unsigned   EXP_HI = DW - 2;
    localparam int unsigned   EXP_LO = DW - 9;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          state;
    logic            start_q;
    logic            issuing;
    logic            rd_valid_q;
    logic            mode_q;
    logic [AW:0]     len_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   acc     [NCH];
    logic [AW-1:0]   acc_idx [NCH];
    logic [NCH-1:0]  upd_c;
    logic            start_edge_c;
    logic            last_rd_c;

    // Map a value onto an unsigned key whose ordering matches the numeric ordering; both zeros share one key.
    function automatic logic [DW-1:0] order_key(input logic [DW-1:0] v);
        logic [DW-1:0] k;
        if (FP_MODE != 0) begin
            if (v[DW-2:0] == '0)
                k = {1'b1, {(DW-1){1'b0}}};
            else if (v[DW-1])
                k = ~v;
            else
                k = {1'b1, v[DW-2:0]};
        end else begin
            k = {~v[DW-1], v[DW-2:0]};
        end
        return k;
    endfunction

    function automatic logic is_nan(input logic [DW-1:0] v);
        return (FP_MODE != 0) && (&v[EXP_HI:EXP_LO]) && (|v[EXP_LO-1:0]);
    endfunction

    function automatic logic better(input logic [DW-1:0] cand, input logic [DW-1:0] cur,
                                    input logic find_min);
        logic [DW-1:0] kc;
        logic [DW-1:0] ka;
        kc = order_key(cand);
        ka = order_key(cur);
        if (is_nan(cand))
            return 1'b0;
        return find_min ? (kc < ka) : (kc > ka);
    endfunction

    assign start_edge_c = start & ~start_q;
    assign last_rd_c    = ({1'b0, rd_addr} == len_q - (AW+1)'(1));

    // Strict compare only, so ties keep the earliest index.
    always_comb begin
        upd_c = '0;
        for (int k = 0; k < int'(NCH); k++)
            upd_c[k] = rd_valid_q & better(rd_data[k*DW +: DW], acc[k], mode_q);
    end

    // Write port mirrors the read data in the cycle it returns.
    assign wr_ena  = rd_valid_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = rd_data;

    for (genvar g = 0; g < int'(NCH); g++) begin : g_out
        assign result[g*DW +: DW]     = acc[g];
        assign result_idx[g*AW +: AW] = acc_idx[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            rd_addr    <= '0;
            start_q    <= 1'b0;
            issuing    <= 1'b0;
            rd_valid_q <= 1'b0;
            mode_q     <= 1'b0;
            len_q      <= '0;
            wr_addr_q  <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                acc[k]     <= ID_MAX;
                acc_idx[k] <= '0;
            end
        end else begin
            start_q    <= start;
            done       <= 1'b0;
            rd_valid_q <= issuing;
            wr_addr_q  <= rd_addr;
            for (int k = 0; k < int'(NCH); k++) begin
                if (upd_c[k]) begin
                    acc[k]     <= rd_data[k*DW +: DW];
                    acc_idx[k] <= wr_addr_q;
                end
            end
            case (state)
                IDLE: begin
                    if (start_edge_c) begin
                        len_q  <= len;
                        mode_q <= mode_min;
                        ready  <= 1'b0;
                        for (int k = 0; k < int'(NCH); k++) begin
                            acc[k]     <= mode_min ? ID_MIN : ID_MAX;
                            acc_idx[k] <= '0;
                        end
                        if (len == '0) begin
                            done  <= 1'b1;
                            state <= HOLD;
                        end else begin
                            issuing <= 1'b1;
                            rd_addr <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issuing) begin
                        if (last_rd_c) begin
                            issuing <= 1'b0;
                            rd_addr <= '0;
                        end else begin
                            rd_addr <= rd_addr + AW'(1);
                        end
                    end else if (rd_valid_q) begin
                        // Final element is folded in on this edge; results are complete next cycle.
                        done  <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (downstream_ready) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_extreme.sv
// Runs an IEEE-float instance and a signed-integer instance side by side on the same memory image
// and compares both against a real-arithmetic reference of the reduction.
module tb_reduce_extreme;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned NCH = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [AW:0] len;
    logic mode_min;
    logic downstream_ready;

    logic              ready_o      [2];
    logic [AW-1:0]     rd_addr_o    [2];
    logic [NCH*DW-1:0] rd_data_i    [2];
    logic [AW-1:0]     wr_addr_o    [2];
    logic [NCH*DW-1:0] wr_data_o    [2];
    logic              wr_ena_o     [2];
    logic [NCH*DW-1:0] result_o     [2];
    logic [NCH*AW-1:0] result_idx_o [2];
    logic              done_o       [2];

    logic [NCH*DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reduce_extreme #(.AW(AW), .DW(DW), .NCH(NCH), .FP_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode_min(mode_min),
        .ready(ready_o[0]), .rd_addr(rd_addr_o[0]), .rd_data(rd_data_i[0]),
        .wr_addr(wr_addr_o[0]), .wr_data(wr_data_o[0]), .wr_ena(wr_ena_o[0]),
        .result(result_o[0]), .result_idx(result_idx_o[0]), .done(done_o[0]),
        .downstream_ready(downstream_ready)
    );

    reduce_extreme #(.AW(AW), .DW(DW), .NCH(NCH), .FP_MODE(0)) dut_int (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode_min(mode_min),
        .ready(ready_o[1]), .rd_addr(rd_addr_o[1]), .rd_data(rd_data_i[1]),
        .wr_addr(wr_addr_o[1]), .wr_data(wr_data_o[1]), .wr_ena(wr_ena_o[1]),
        .result(result_o[1]), .result_idx(result_idx_o[1]), .done(done_o[1]),
        .downstream_ready(downstream_ready)
    );

    // One-cycle-latency source memory per instance.
    always @(posedge clk) begin
        rd_data_i[0] <= mem[rd_addr_o[0]];
        rd_data_i[1] <= mem[rd_addr_o[1]];
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real mag;
        int  e;
        e = int'(b[30:23]);
        if (e == 255)
            mag = 1.0e300;
        else if (e == 0)
            mag = real'(b[22:0]) * (2.0 ** -149);
        else
            mag = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -mag : mag;
    endfunction

    function automatic logic f_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    // Reference: scan the first n words, keep the first strictly better element per lane.
    task automatic model(input int n, input logic mm, input logic fp,
                         output logic [127:0] res, output logic [15:0] idx);
        logic [31:0] best;
        logic [31:0] v;
        logic        upd;
        int          bi;
        for (int l = 0; l < 4; l++) begin
            best = fp ? (mm ? 32'h7F80_0000 : 32'hFF80_0000) : (mm ? 32'h7FFF_FFFF : 32'h8000_0000);
            bi = 0;
            for (int i = 0; i < n; i++) begin
                v = mem[i][l*32 +: 32];
                if (fp)
                    upd = !f_nan(v) && (mm ? (f2r(v) < f2r(best)) : (f2r(v) > f2r(best)));
                else
                    upd = mm ? ($signed(v) < $signed(best)) : ($signed(v) > $signed(best));
                if (upd) begin
                    best = v;
                    bi = i;
                end
            end
            res[l*32 +: 32] = best;
            idx[l*4 +: 4]   = 4'(bi);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 9))
            0: return 32'h7FC0_0001;
            1: return 32'h0000_0000;
            2: return 32'h8000_0000;
            3: return 32'h7F80_0000;
            4: return 32'hFF80_0000;
            5: return 32'h3F80_0000;
            6: return 32'hC040_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic load_mem(input int pat);
        logic [31:0] p1 [8];
        logic [31:0] p2 [8];
        p1 = '{32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h4040_0000,
               32'h3F00_0000, 32'h0000_0000, 32'hBF80_0000, 32'h4000_0000};
        p2 = '{32'h7FC0_0000, 32'h3F80_0000, 32'h8000_0000, 32'h0000_0000,
               32'h4000_0000, 32'hFFC0_0000, 32'h3F00_0000, 32'h8000_0000};
        for (int i = 0; i < int'(DEPTH); i++)
            for (int l = 0; l < 4; l++)
                mem[i][l*32 +: 32] = rand_word();
        for (int i = 0; i < 8; i++) begin
            if (pat == 1) mem[i][31:0] = p1[i];
            if (pat == 2) mem[i][31:0] = p2[i];
        end
    endtask

    // One complete run; every cycle from the start edge until ready returns is checked on both instances.
    task automatic run_case(input int n, input logic mm, input int dr_delay, input logic spurious,
                            output logic [31:0] fp_res0, output logic [3:0] fp_idx0);
        logic [127:0] exp_res [2];
        logic [15:0]  exp_idx [2];
        int d_cyc;
        d_cyc = (n == 0) ? 0 : n + 1;
        model(n, mm, 1'b1, exp_res[0], exp_idx[0]);
        model(n, mm, 1'b0, exp_res[1], exp_idx[1]);
        start = 1'b0;
        downstream_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        len = (AW+1)'(n);
        mode_min = mm;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d ready_at_start", d), 128'(ready_o[d]), 128'(1));
            chk($sformatf("d%0d rd_addr_idle", d), 128'(rd_addr_o[d]), 128'(0));
        end
        for (int c = 0; c <= d_cyc + dr_delay + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (spurious && c == d_cyc + 2) start = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (c <= d_cyc) begin
                    chk($sformatf("d%0d n%0d c%0d rd_addr", d, n, c), 128'(rd_addr_o[d]),
                        128'((c < n) ? c : 0));
                    chk($sformatf("d%0d n%0d c%0d wr_ena", d, n, c), 128'(wr_ena_o[d]),
                        128'((c >= 1 && c <= n) ? 1 : 0));
                    if (c >= 1 && c <= n) begin
                        chk($sformatf("d%0d c%0d wr_addr", d, c), 128'(wr_addr_o[d]), 128'(c - 1));
                        chk($sformatf("d%0d c%0d wr_data", d, c), wr_data_o[d], mem[c-1]);
                    end
                    chk($sformatf("d%0d n%0d c%0d done", d, n, c), 128'(done_o[d]),
                        128'((c == d_cyc) ? 1 : 0));
                    chk($sformatf("d%0d c%0d ready_busy", d, c), 128'(ready_o[d]), 128'(0));
                    if (c == d_cyc) begin
                        chk($sformatf("d%0d n%0d result", d, n), result_o[d], exp_res[d]);
                        chk($sformatf("d%0d n%0d result_idx", d, n), 128'(result_idx_o[d]),
                            128'(exp_idx[d]));
                    end
                end else begin
                    chk($sformatf("d%0d c%0d hold_done", d, c), 128'(done_o[d]), 128'(0));
                    chk($sformatf("d%0d c%0d hold_wr_ena", d, c), 128'(wr_ena_o[d]), 128'(0));
                    chk($sformatf("d%0d c%0d hold_rd_addr", d, c), 128'(rd_addr_o[d]), 128'(0));
                    chk($sformatf("d%0d c%0d hold_result", d, c), result_o[d], exp_res[d]);
                    chk($sformatf("d%0d c%0d hold_idx", d, c), 128'(result_idx_o[d]),
                        128'(exp_idx[d]));
                    chk($sformatf("d%0d c%0d hold_ready", d, c), 128'(ready_o[d]),
                        128'((c == d_cyc + dr_delay + 1) ? 1 : 0));
                end
            end
            if (c == d_cyc + dr_delay) downstream_ready = 1'b1;
        end
        fp_res0 = result_o[0][31:0];
        fp_idx0 = result_idx_o[0][3:0];
    endtask

    // Abort a run with reset while element 3 is being read.
    task automatic reset_mid_run();
        load_mem(0);
        start = 1'b0;
        downstream_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        len = (AW+1)'(10);
        mode_min = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d rst%0d ready", d, c), 128'(ready_o[d]), 128'(1));
                chk($sformatf("d%0d rst%0d done", d, c), 128'(done_o[d]), 128'(0));
                chk($sformatf("d%0d rst%0d wr_ena", d, c), 128'(wr_ena_o[d]), 128'(0));
                chk($sformatf("d%0d rst%0d rd_addr", d, c), 128'(rd_addr_o[d]), 128'(0));
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int          n;
        logic        mm;
        int          dr;
        logic        spurious;
        int          pat;
        logic        chk_const;
        logic [31:0] exp_res0;
        logic [3:0]  exp_idx0;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [31:0] r0;
        logic [3:0]  i0;

        vecs[0] = '{8,  1'b0, 0, 1'b0, 1, 1'b1, 32'h4040_0000, 4'd1};
        vecs[1] = '{8,  1'b1, 0, 1'b0, 2, 1'b1, 32'h8000_0000, 4'd2};
        vecs[2] = '{0,  1'b0, 0, 1'b0, 0, 1'b1, 32'hFF80_0000, 4'd0};
        vecs[3] = '{0,  1'b1, 5, 1'b1, 0, 1'b1, 32'h7F80_0000, 4'd0};
        vecs[4] = '{5,  1'b0, 5, 1'b1, 0, 1'b0, 32'h0,         4'd0};
        vecs[5] = '{16, 1'b0, 1, 1'b0, 0, 1'b0, 32'h0,         4'd0};
        vecs[6] = '{16, 1'b1, 0, 1'b0, 0, 1'b0, 32'h0,         4'd0};
        vecs[7] = '{1,  1'b1, 2, 1'b0, 0, 1'b0, 32'h0,         4'd0};

        rst = 1'b0;
        start = 1'b0;
        len = '0;
        mode_min = 1'b0;
        downstream_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset ready_fp", 128'(ready_o[0]), 128'(1));
        chk("reset done_fp", 128'(done_o[0]), 128'(0));
        chk("reset wr_ena_fp", 128'(wr_ena_o[0]), 128'(0));
        chk("reset rd_addr_fp", 128'(rd_addr_o[0]), 128'(0));
        chk("reset result_fp", result_o[0], {4{32'hFF80_0000}});
        chk("reset result_int", result_o[1], {4{32'h8000_0000}});
        chk("reset idx_fp", 128'(result_idx_o[0]), 128'(0));
        chk("reset idx_int", 128'(result_idx_o[1]), 128'(0));

        for (int v = 0; v < 8; v++) begin
            load_mem(vecs[v].pat);
            run_case(vecs[v].n, vecs[v].mm, vecs[v].dr, vecs[v].spurious, r0, i0);
            if (vecs[v].chk_const) begin
                chk($sformatf("vec%0d lane0_result", v), 128'(r0), 128'(vecs[v].exp_res0));
                chk($sformatf("vec%0d lane0_idx", v), 128'(i0), 128'(vecs[v].exp_idx0));
            end
        end

        reset_mid_run();
        load_mem(1);
        run_case(8, 1'b0, 0, 1'b0, r0, i0);
        chk("post_reset lane0_result", 128'(r0), 128'(32'h4040_0000));
        chk("post_reset lane0_idx", 128'(i0), 128'(1));

        for (int r = 0; r < 12; r++) begin
            load_mem(0);
            run_case(int'($urandom_range(0, DEPTH)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'b0, r0, i0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
